pong_core_param: RTL and testbench

//  Two-player paddle/ball game engine for the VGA path: paddle tracking, ball motion, scoring and serve control.

---
 rtl/pong_core_param.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_pong_core_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_core_param.sv
// Two-player paddle/ball game engine: paddle tracking, ball motion, scoring and serve
// control, with a registered RGB332 renderer driven by the VGA scan position.
module pong_core_param #(
   parameter int H_DISP      = 800,
   parameter int V_DISP      = 600,
   parameter int WALL        = 40,
   parameter int BALL        = 40,
   parameter int PAD_W       = 100,
   parameter int PAD_H       = 20,
   parameter int PAD_STEP    = 20,
   parameter int TICK        = 500000,
   parameter int BALL_SPD    = 1,
   parameter int SERVE_TICKS = 100,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_flag1,
   input  logic               key_flag2,
   input  logic               key_flag3,
   input  logic               key_flag4,
   input  logic               start,
   input  logic [9:0]         vga_xide,
   input  logic [9:0]         vga_yide,
   output logic [7:0]         vga_data,
   output logic [SCORE_W-1:0] score_bot,
   output logic [SCORE_W-1:0] score_top,
   output logic               game_over
);

   localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int SRV_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

   localparam logic [10:0] HD       = 11'(H_DISP);
   localparam logic [10:0] VD       = 11'(V_DISP);
   localparam logic [10:0] WL       = 11'(WALL);
   localparam logic [10:0] BS       = 11'(BALL);
   localparam logic [10:0] PW       = 11'(PAD_W);
   localparam logic [10:0] PH       = 11'(PAD_H);
   localparam logic [10:0] STEP     = 11'(PAD_STEP);
   localparam logic [10:0] SPD      = 11'(BALL_SPD);
   localparam logic [10:0] BX0      = 11'((H_DISP - BALL) / 2);
   localparam logic [10:0] BY0      = 11'((V_DISP - BALL) / 2);
   localparam logic [10:0] PAD0     = 11'((H_DISP - PAD_W) / 2);
   localparam logic [10:0] PAD_MAX  = 11'(H_DISP - WALL - PAD_W);
   localparam logic [10:0] BX_MAX   = 11'(H_DISP - WALL - BALL);
   localparam logic [10:0] BY_BOT   = 11'(V_DISP - PAD_H - BALL);
   localparam logic [10:0] RIGHT_IN = 11'(H_DISP - WALL);
   localparam logic [10:0] BOT_LINE = 11'(V_DISP - PAD_H);

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK - 1);
   localparam logic [SRV_W-1:0]   SRV_LAST  = SRV_W'(SERVE_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   localparam logic [7:0] COL_OFF   = 8'h00;
   localparam logic [7:0] COL_BLUE  = 8'h03;
   localparam logic [7:0] COL_BLACK = 8'h00;
   localparam logic [7:0] COL_GREEN = 8'h1C;
   localparam logic [7:0] COL_WHITE = 8'hFF;
   localparam logic [7:0] COL_RED   = 8'hE0;

   typedef enum logic [2:0] {
      IDLE,
      SERVE,
      PLAY,
      POINT,
      OVER
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 tick;
   logic [SRV_W-1:0]     srv_cnt, srv_cnt_nxt;
   logic [10:0]          bx, by, bx_nxt, by_nxt;
   logic                 x_right, x_right_nxt;
   logic                 y_down, y_down_nxt;
   logic                 serve_dir, serve_dir_nxt;
   logic                 scorer_top, scorer_top_nxt;
   logic [SCORE_W-1:0]   score_bot_nxt, score_top_nxt;
   logic [SCORE_W-1:0]   score_inc;
   logic [10:0]          pad_bot, pad_top;
   logic [10:0]          px, py;
   logic                 in_ball, in_bot, in_top;
   logic [7:0]           pix;

   // Clamped paddle step; opposing pulses in the same cycle cancel out.
   function automatic logic [10:0] pad_move(input logic [10:0] x, input logic right,
                                            input logic left);
      pad_move = x;
      if (right && !left) begin
         pad_move = (x + STEP > PAD_MAX) ? PAD_MAX : x + STEP;
      end else if (left && !right) begin
         pad_move = (x < WL + STEP) ? WL : x - STEP;
      end
   endfunction

   assign tick      = (cnt == CNT_LAST);
   assign game_over = (state == OVER);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pad_bot <= PAD0;
         pad_top <= PAD0;
      end else begin
         pad_bot <= pad_move(pad_bot, key_flag1, key_flag2);
         pad_top <= pad_move(pad_top, key_flag3, key_flag4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         srv_cnt    <= '0;
         bx         <= BX0;
         by         <= BY0;
         x_right    <= 1'b1;
         y_down     <= 1'b1;
         serve_dir  <= 1'b1;
         scorer_top <= 1'b0;
         score_bot  <= '0;
         score_top  <= '0;
      end else begin
         state      <= state_nxt;
         srv_cnt    <= srv_cnt_nxt;
         bx         <= bx_nxt;
         by         <= by_nxt;
         x_right    <= x_right_nxt;
         y_down     <= y_down_nxt;
         serve_dir  <= serve_dir_nxt;
         scorer_top <= scorer_top_nxt;
         score_bot  <= score_bot_nxt;
         score_top  <= score_top_nxt;
      end
   end

   assign score_inc = scorer_top ? ((score_top == SCORE_MAX) ? score_top : score_top + 1'b1)
                                 : ((score_bot == SCORE_MAX) ? score_bot : score_bot + 1'b1);

   // A fresh game (from IDLE or OVER) always serves right and down; later serves
   // alternate horizontally and head toward whoever lost the last point.
   always_comb begin
      state_nxt      = state;
      srv_cnt_nxt    = srv_cnt;
      bx_nxt         = bx;
      by_nxt         = by;
      x_right_nxt    = x_right;
      y_down_nxt     = y_down;
      serve_dir_nxt  = serve_dir;
      scorer_top_nxt = scorer_top;
      score_bot_nxt  = score_bot;
      score_top_nxt  = score_top;
      unique case (state)
         IDLE, OVER: begin
            if (state == IDLE) begin
               bx_nxt = BX0;
               by_nxt = BY0;
            end
            if (start) begin
               state_nxt     = SERVE;
               srv_cnt_nxt   = '0;
               bx_nxt        = BX0;
               by_nxt        = BY0;
               x_right_nxt   = 1'b1;
               y_down_nxt    = 1'b1;
               serve_dir_nxt = 1'b1;
               score_bot_nxt = '0;
               score_top_nxt = '0;
            end
         end
         SERVE: begin
            bx_nxt = BX0;
            by_nxt = BY0;
            if (tick) begin
               if (srv_cnt == SRV_LAST) begin
                  state_nxt = PLAY;
               end else begin
                  srv_cnt_nxt = srv_cnt + 1'b1;
               end
            end
         end
         PLAY: begin
            if (tick) begin
               if (!x_right) begin
                  if (bx < WL + SPD) begin
                     bx_nxt      = WL;
                     x_right_nxt = 1'b1;
                  end else begin
                     bx_nxt = bx - SPD;
                  end
               end else begin
                  if (bx + BS + SPD > RIGHT_IN) begin
                     bx_nxt      = BX_MAX;
                     x_right_nxt = 1'b0;
                  end else begin
                     bx_nxt = bx + SPD;
                  end
               end
               // Paddle hit tests use the ball position from before this tick's move.
               if (y_down) begin
                  if (by + BS + SPD > BOT_LINE) begin
                     if ((bx + BS > pad_bot) && (bx < pad_bot + PW)) begin
                        by_nxt     = BY_BOT;
                        y_down_nxt = 1'b0;
                     end else begin
                        state_nxt      = POINT;
                        scorer_top_nxt = 1'b1;
                     end
                  end else begin
                     by_nxt = by + SPD;
                  end
               end else begin
                  if (by < PH + SPD) begin
                     if ((bx + BS > pad_top) && (bx < pad_top + PW)) begin
                        by_nxt     = PH;
                        y_down_nxt = 1'b1;
                     end else begin
                        state_nxt      = POINT;
                        scorer_top_nxt = 1'b0;
                     end
                  end else begin
                     by_nxt = by - SPD;
                  end
               end
            end
         end
         POINT: begin
            if (scorer_top) begin
               score_top_nxt = score_inc;
            end else begin
               score_bot_nxt = score_inc;
            end
            if (32'(score_inc) >= WIN_SCORE) begin
               state_nxt = OVER;
            end else begin
               state_nxt     = SERVE;
               srv_cnt_nxt   = '0;
               bx_nxt        = BX0;
               by_nxt        = BY0;
               serve_dir_nxt = ~serve_dir;
               x_right_nxt   = ~serve_dir;
               y_down_nxt    = scorer_top;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      px      = {1'b0, vga_xide};
      py      = {1'b0, vga_yide};
      in_ball = (px >= bx) && (px < bx + BS) && (py >= by) && (py < by + BS);
      in_bot  = (py >= BOT_LINE) && (px >= pad_bot) && (px < pad_bot + PW);
      in_top  = (py < PH) && (px >= pad_top) && (px < pad_top + PW);
      if (px >= HD || py >= VD) begin
         pix = COL_OFF;
      end else if (px < WL || px >= RIGHT_IN) begin
         pix = COL_BLUE;
      end else if (in_ball) begin
         pix = COL_BLACK;
      end else if (in_bot || in_top) begin
         pix = COL_GREEN;
      end else if (state == OVER) begin
         pix = COL_RED;
      end else begin
         pix = COL_WHITE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vga_data <= COL_OFF;
      end else begin
         vga_data <= pix;
      end
   end

endmodule

// File: tb/tb_pong_core_param.sv
// Self-checking bench for pong_core_param with a fast tick; pixel probes are queued
// with their expected colour when driven and compared when the registered pixel arrives.
module tb_pong_core_param;

   localparam int TICK = 4;
   localparam logic [7:0] BLUE  = 8'h03;
   localparam logic [7:0] BLACK = 8'h00;
   localparam logic [7:0] GREEN = 8'h1C;
   localparam logic [7:0] WHITE = 8'hFF;
   localparam logic [7:0] RED   = 8'hE0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_flag1 = 1'b0, key_flag2 = 1'b0, key_flag3 = 1'b0, key_flag4 = 1'b0;
   logic       start = 1'b0;
   logic [9:0] vga_xide = '0, vga_yide = '0;
   logic [7:0] vga_data;
   logic [3:0] score_bot, score_top;
   logic       game_over;

   int total = 0;
   int bad   = 0;
   int phase = 0;
   int ticks = 0;
   int t0;
   int lt;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   always #5 clk = ~clk;

   pong_core_param #(.TICK(TICK), .SERVE_TICKS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_flag1(key_flag1), .key_flag2(key_flag2),
      .key_flag3(key_flag3), .key_flag4(key_flag4),
      .start(start), .vga_xide(vga_xide), .vga_yide(vga_yide),
      .vga_data(vga_data), .score_bot(score_bot), .score_top(score_top),
      .game_over(game_over)
   );

   // Independent tick-phase model: a motion tick lands on the edge that wraps the phase.
   always @(posedge clk) begin
      if (!rst_n) begin
         phase <= 0;
      end else if (phase == TICK - 1) begin
         phase <= 0;
         ticks <= ticks + 1;
      end else begin
         phase <= phase + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic probePixel(input int x, input int y, input logic [7:0] want, input string tag);
      vga_xide = 10'(x);
      vga_yide = 10'(y);
      exp_q.push_back(want);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      checkOutput(tag_q.pop_front(), {24'h0, vga_data}, {24'h0, exp_q.pop_front()});
   endtask

   // Bit order: {start, key_flag4, key_flag3, key_flag2, key_flag1}, held one cycle.
   task automatic applyStimulus(input logic [4:0] stim);
      {start, key_flag4, key_flag3, key_flag2, key_flag1} = stim;
      @(posedge clk);
      #1;
      {start, key_flag4, key_flag3, key_flag2, key_flag1} = 5'b0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_vga", {24'h0, vga_data}, 32'h0);
      checkOutput("rst_score_bot", {28'h0, score_bot}, 32'h0);
      checkOutput("rst_score_top", {28'h0, score_top}, 32'h0);
      checkOutput("rst_game_over", {31'h0, game_over}, 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic waitTickTo(input int t);
      while (ticks < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Four probes fill exactly one tick window when called just after a tick edge.
   task automatic checkBall(input int x, input int y, input logic [7:0] bg, input string tag);
      probePixel(x, y, BLACK, {tag, "_tl"});
      probePixel(x - 1, y, bg, {tag, "_left"});
      probePixel(x, y - 1, bg, {tag, "_above"});
      probePixel(x + 39, y + 39, BLACK, {tag, "_br"});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetDut();
      probePixel(350, 590, GREEN, "rst_bot_left");
      probePixel(349, 590, WHITE, "rst_bot_before");
      probePixel(449, 590, GREEN, "rst_bot_right");
      probePixel(450, 590, WHITE, "rst_bot_after");
      probePixel(350, 10, GREEN, "rst_top_left");
      probePixel(349, 10, WHITE, "rst_top_before");
      checkBall(380, 280, WHITE, "rst_ball");
      probePixel(39, 100, BLUE, "wall_left");
      probePixel(40, 100, WHITE, "inside_left");
      probePixel(760, 100, BLUE, "wall_right");
      probePixel(800, 0, 8'h00, "off_x");
      probePixel(100, 600, 8'h00, "off_y");

      repeat (20) applyStimulus(5'b00001);
      probePixel(659, 590, WHITE, "clamp_r_before");
      probePixel(660, 590, GREEN, "clamp_r_left");
      probePixel(759, 590, GREEN, "clamp_r_right");
      probePixel(760, 590, BLUE, "clamp_r_wall");
      repeat (40) applyStimulus(5'b00010);
      probePixel(40, 590, GREEN, "clamp_l_left");
      probePixel(139, 590, GREEN, "clamp_l_right");
      probePixel(140, 590, WHITE, "clamp_l_after");
      repeat (5) applyStimulus(5'b00001);
      applyStimulus(5'b00011);
      probePixel(139, 590, WHITE, "both_before");
      probePixel(140, 590, GREEN, "both_left");
      probePixel(240, 590, WHITE, "both_after");
      applyStimulus(5'b00100);
      probePixel(369, 10, WHITE, "top_r_before");
      probePixel(370, 10, GREEN, "top_r_left");
      probePixel(470, 10, WHITE, "top_r_after");
      repeat (2) applyStimulus(5'b01000);
      probePixel(329, 10, WHITE, "top_l_before");
      probePixel(330, 10, GREEN, "top_l_left");
      probePixel(140, 590, GREEN, "bot_untouched");

      // Rally: bottom paddle at 610 returns the first descent, the top paddle misses.
      resetDut();
      repeat (13) applyStimulus(5'b00001);
      probePixel(609, 590, WHITE, "b_pad_before");
      probePixel(610, 590, GREEN, "b_pad_left");
      applyStimulus(5'b10000);
      t0 = ticks;
      lt = t0 + 2;
      waitTickTo(lt);
      checkBall(380, 280, WHITE, "launch");
      checkBall(381, 281, WHITE, "first_move");
      applyStimulus(5'b10000);
      waitTickTo(lt + 260);
      checkBall(640, 540, WHITE, "at_paddle");
      checkBall(641, 540, WHITE, "hit_hold");
      checkBall(642, 539, WHITE, "hit_up");
      checkOutput("hit_score_bot", {28'h0, score_bot}, 32'h0);
      checkOutput("hit_score_top", {28'h0, score_top}, 32'h0);
      waitTickTo(lt + 340);
      checkBall(720, 461, WHITE, "x_edge");
      checkBall(720, 460, WHITE, "x_reflect");
      checkBall(719, 459, WHITE, "x_back");
      waitTickTo(lt + 781);
      checkBall(280, 20, WHITE, "top_line");
      checkOutput("point_pending", {28'h0, score_bot}, 32'h0);
      @(posedge clk);
      #1;
      t0 = ticks;
      checkOutput("top_miss_score_bot", {28'h0, score_bot}, 32'h1);
      checkOutput("top_miss_score_top", {28'h0, score_top}, 32'h0);
      checkOutput("top_miss_over", {31'h0, game_over}, 32'h0);
      probePixel(380, 280, BLACK, "reserve_centre");
      probePixel(379, 280, WHITE, "reserve_left");
      lt = t0 + 2;
      waitTickTo(lt);
      checkBall(380, 280, WHITE, "serve2_launch");
      checkBall(379, 279, WHITE, "serve2_move");

      // Nine bottom misses: paddle parked away from the ball on each descent.
      resetDut();
      repeat (16) applyStimulus(5'b00010);
      applyStimulus(5'b10000);
      for (int n = 1; n <= 9; n++) begin
         t0 = ticks;
         lt = t0 + 2;
         waitTickTo(lt);
         checkBall(380, 280, WHITE, $sformatf("p%0d_launch", n));
         checkBall((n % 2 == 1) ? 381 : 379, 281, WHITE, $sformatf("p%0d_move", n));
         if (n % 2 == 0) begin
            repeat (31) applyStimulus(5'b00001);
         end else if (n > 1) begin
            repeat (31) applyStimulus(5'b00010);
         end
         waitTickTo(lt + 261);
         @(posedge clk);
         #1;
         checkOutput($sformatf("p%0d_score_top", n), {28'h0, score_top}, 32'(n));
         checkOutput($sformatf("p%0d_score_bot", n), {28'h0, score_bot}, 32'h0);
         checkOutput($sformatf("p%0d_over", n), {31'h0, game_over}, (n == 9) ? 32'h1 : 32'h0);
         if (n < 9) begin
            probePixel(380, 280, BLACK, $sformatf("p%0d_centre", n));
            probePixel(379, 280, WHITE, $sformatf("p%0d_centre_left", n));
         end
      end
      probePixel(100, 300, RED, "over_bg");
      probePixel(20, 300, BLUE, "over_wall");
      probePixel(660, 560, BLACK, "over_ball");
      probePixel(700, 560, RED, "over_ball_right");
      waitTickTo(ticks + 3);
      probePixel(660, 560, BLACK, "frozen_ball");
      probePixel(700, 560, RED, "frozen_right");
      checkOutput("over_hold", {31'h0, game_over}, 32'h1);
      applyStimulus(5'b10000);
      checkOutput("restart_over", {31'h0, game_over}, 32'h0);
      checkOutput("restart_score_top", {28'h0, score_top}, 32'h0);
      checkOutput("restart_score_bot", {28'h0, score_bot}, 32'h0);
      probePixel(100, 300, WHITE, "restart_bg");
      probePixel(380, 280, BLACK, "restart_centre");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
